lbp_window: RTL and testbench
=============================

# lbp_window

Sliding 3×3 neighbourhood generator for the LBP pipeline. Accepts a raster pixel stream one pixel per enabled clock. Buffers the two previous image rows in line memories and presents the full 3×3 window each time a pixel arrives whose window lies wholly inside the image. Sits directly downstream of the pixel source and feeds the LBP comparator stage. Its output bus is registered through the delay-line latch stage.

## Interface
Parameters:
- `WIDTH`, default 8: pixel bit width.
- `LINE_LEN`, default 640: pixels per image row; must be ≥ 3.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `ce`, in, 1: pixel-valid strobe; one pixel is accepted per cycle with `ce`=1.
- `in`, in, `WIDTH`: pixel, raster order (row-major, left to right).
- `sof`, in, 1: start of frame; present only with `LBP_WINDOW_SOF_EN`.
- `win`, out, 9·`WIDTH`: window. Slot k occupies bits [k·WIDTH +: WIDTH]; k = 3·row + col; row 0 is the oldest row; slot 8 is the newest pixel.
- `win_valid`, out, 1: `win` holds a complete in-image window.

## Operation
- `col` counter: 0..LINE_LEN-1. It increments on every accepted pixel and wraps to 0 after LINE_LEN-1. Each wrap increments `row`.
- `row` counter: 0..2, saturating at 2. It only records whether two full rows are buffered.
- Line buffers:
  - Two circular buffers, each LINE_LEN deep, sharing the `col` address.
  - On an accepted pixel, buffer A reads the pixel from one row above at `col`, and buffer B reads the pixel from two rows above.
  - In the same cycle, B is written with A's old entry and A is written with `in`.
- Window shift register: 3×3. On an accepted pixel, each row shifts left by one slot. The new right column, top to bottom, is {B read, A read, `in`}.
- `win_valid` <= `ce` && `row`==2 && `col`≥2, evaluated on the pixel being accepted.
- With `ce`=0, all state holds, including `win` and `win_valid`. `win_valid` is not cleared by idle cycles.
- Across a row wrap, the shift register keeps stale right-edge pixels. The `col`≥2 gate guarantees these stale pixels are never flagged valid.
- Reset (any time, including mid-row):
  - `col`, `row`, `win`, and `win_valid` go to 0.
  - Line-buffer contents are not cleared; they are unobservable until refilled.

## Timing
- Latency: 1 cycle. A pixel accepted at edge n appears in slot 8 of `win`, with `win_valid` updated, after edge n.
- First valid window in a stream comes with pixel (row 2, col 2), i.e. the (2·LINE_LEN+3)-th pixel. Its centre is pixel (1,1).
- Per row after the first two: LINE_LEN−2 valid windows. The first two pixels of each row produce `win_valid`=0.
- Throughput: one window per cycle at `ce`=1 sustained; there is no backpressure.
- Line buffers use synchronous read-before-write at the same address, single port per buffer.

## Configuration
- `LBP_WINDOW_SOF_EN` defined:
  - `sof` port exists. `sof`=1 together with `ce`=1 treats `in` as pixel (0,0): `col`=0 and `row`=0 are used for this pixel, and the counters continue from there.
  - `win_valid` drops to 0 on that pixel.
  - `sof` with `ce`=0 is ignored.
- Not defined: no `sof` port. The stream is treated as one infinite image, and `row` stays saturated across frame boundaries.

## Structure
- Shared package `lbp_pkg`:
  - window slot index constants (`WIN_TL`..`WIN_BR`, `WIN_C`=4)
  - window size constant 9
  - default pixel width
- Sub-module `lbp_line_buf`: parameters WIDTH and LINE_LEN; ports clk, ce, addr, din, dout; read-before-write; instantiated twice.
- Counters, shift register, and valid logic live in the top module.

## Test plan
All scenarios use LINE_LEN=4, WIDTH=8, and pixel value = 4·row + col.
- Stream pixels 0..15 with continuous `ce` → `win_valid` is first 1 after pixel 10, with `win`={0,1,2,4,5,6,8,9,10}. After pixel 11: {1,2,3,5,6,7,9,10,11}.
- Continue the same stream → pixels 12 and 13 give `win_valid`=0. Pixel 14 gives {4,5,6,8,9,10,12,13,14}. Pixel 15 gives {5,6,7,9,10,11,13,14,15}.
- Insert random `ce`=0 gaps (1–5 cycles) into the stream → the same window sequence as without gaps. `win` and `win_valid` hold during the gaps.
- Assert `rst`=0 asynchronously mid-row 2, between clock edges → `win`=0 and `win_valid`=0 immediately. After release, restart from pixel 0; the first valid window is again after pixel 10 and equals {0,1,2,4,5,6,8,9,10}.
- With `LBP_WINDOW_SOF_EN`: send 11 pixels, then `sof` with new pixel 0 → `win_valid`=0 for the next 10 pixels, then 1 with the new frame's window.
- LINE_LEN=3 → exactly one valid window per row from row 2 onward, at col 2.

Source files
------------

// File: rtl/lbp_pkg.sv
// lbp_pkg -- shared constants for the LBP pipeline.
//
// Contents:
//   WIN_TL..WIN_BR : slot index of each 3x3 window position.
//                    The slot index is 3*row + col. Row 0 is the oldest image row.
//   WIN_SIZE       : number of pixels in a window (9).
//   PIX_WIDTH_DEFAULT : default pixel bit width.
package lbp_pkg;

    localparam int WIN_TL = 0;
    localparam int WIN_T  = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_L  = 3;
    localparam int WIN_C  = 4;
    localparam int WIN_R  = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_B  = 7;
    localparam int WIN_BR = 8;

    localparam int WIN_SIZE = 9;

    localparam int PIX_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/lbp_line_buf.sv
// lbp_line_buf -- single-port circular line memory with a registered
// read-before-write access.
//
// Parameters:
//   WIDTH    : data width.
//   LINE_LEN : depth, in entries.
//
// Ports:
//   clk  : clock. Everything happens on the rising edge.
//   ce   : access enable. When ce is 0, the memory and dout hold.
//   addr : entry address.
//   din  : data written to mem[addr] when ce is 1.
//   dout : the old content of mem[addr], registered on the access.
//
// There is no reset. The contents only become meaningful once they have
// been refilled after a reset.
module lbp_line_buf #(
    parameter int WIDTH    = 8,
    parameter int LINE_LEN = 640,
    localparam int AW      = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1
) (
    input  logic             clk,
    input  logic             ce,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [LINE_LEN];
    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (ce) begin
            dout_q    <= mem[addr];
            mem[addr] <= din;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/lbp_window.sv
// lbp_window -- sliding 3x3 neighbourhood generator for the LBP pipeline.
//
// The block buffers the two previous image rows. It presents the full 3x3
// window each time an accepted pixel has its window lying wholly inside
// the image.
//
// Parameters:
//   WIDTH    : pixel width.
//   LINE_LEN : pixels per row. Must be at least 3.
//
// Ports:
//   clk       : clock. Everything happens on the rising edge.
//   rst       : asynchronous reset, active low.
//   ce        : pixel strobe. One pixel is accepted per cycle while ce is 1.
//   in        : pixel, in raster order.
//   sof       : start of frame. Present only when LBP_WINDOW_SOF_EN is defined.
//   win       : the window. Slot k is bits [k*WIDTH +: WIDTH], with k = 3*row + col.
//   win_valid : win holds a complete in-image window.
//
// Optional feature: define LBP_WINDOW_SOF_EN to add the sof port.
module lbp_window
    import lbp_pkg::*;
#(
    parameter int WIDTH    = PIX_WIDTH_DEFAULT,
    parameter int LINE_LEN = 640
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic [WIDTH-1:0]          in,
`ifdef LBP_WINDOW_SOF_EN
    input  logic                      sof,
`endif
    output logic [WIN_SIZE*WIDTH-1:0] win,
    output logic                      win_valid
);

    localparam int CW = $clog2(LINE_LEN);
    localparam int BW = (LINE_LEN - 1 > 1) ? $clog2(LINE_LEN - 1) : 1;
    localparam logic [CW-1:0] COL_LAST  = CW'(LINE_LEN - 1);
    localparam logic [BW-1:0] BPTR_LAST = BW'(LINE_LEN - 2);

    logic [CW-1:0]    col_q, col_d, col_eff;
    logic [1:0]       row_q, row_d, row_eff;
    logic [BW-1:0]    bptr_q, bptr_d;
    logic [WIDTH-1:0] left_q [3][2];
    logic [WIDTH-1:0] left_d [3][2];
    logic [WIDTH-1:0] in_q, in_d;
    logic             live_q, live_d;
    logic             win_valid_q, win_valid_d;
    logic             frame_start;
    logic [WIDTH-1:0] a_dout, b_dout;
    logic [WIDTH-1:0] right [3];

`ifdef LBP_WINDOW_SOF_EN
    assign frame_start = ce & sof;
`else
    assign frame_start = 1'b0;
`endif

    // A start-of-frame pixel is handled as position (0,0), whatever the
    // counters held before it.
    always_comb begin
        col_eff = col_q;
        row_eff = row_q;
        if (frame_start) begin
            col_eff = '0;
            row_eff = '0;
        end
    end

    // Buffer A is addressed by the column. Its registered read returns the
    // pixel from one row above. That register is itself the middle-row
    // right slot of the window.
    lbp_line_buf #(
        .WIDTH    (WIDTH),
        .LINE_LEN (LINE_LEN)
    ) u_buf_a (
        .clk  (clk),
        .ce   (ce),
        .addr (col_eff),
        .din  (in),
        .dout (a_dout)
    );

    // Buffer B takes what buffer A read. Buffer A's read is already one
    // pixel old, so B runs as a delay line that is one entry shorter. It
    // uses its own wrapping pointer. This keeps both memories single-port
    // with a registered read. B's output is still the pixel from two rows
    // above at the current column.
    lbp_line_buf #(
        .WIDTH    (WIDTH),
        .LINE_LEN (LINE_LEN - 1)
    ) u_buf_b (
        .clk  (clk),
        .ce   (ce),
        .addr (bptr_q),
        .din  (a_dout),
        .dout (b_dout)
    );

    // The RAM read registers have no reset. Until the first pixel after a
    // reset, their slots are forced to zero so that win reads all zeros.
    assign right[0] = live_q ? b_dout : '0;
    assign right[1] = live_q ? a_dout : '0;
    assign right[2] = in_q;

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        bptr_d      = bptr_q;
        left_d      = left_q;
        in_d        = in_q;
        live_d      = live_q;
        win_valid_d = win_valid_q;
        if (ce) begin
            col_d  = (col_eff == COL_LAST) ? '0 : col_eff + 1'b1;
            row_d  = (col_eff == COL_LAST && row_eff != 2'd2) ? row_eff + 2'd1 : row_eff;
            bptr_d = (bptr_q == BPTR_LAST) ? '0 : bptr_q + 1'b1;
            for (int r = 0; r < 3; r++) begin
                left_d[r][0] = left_q[r][1];
                left_d[r][1] = right[r];
            end
            in_d        = in;
            live_d      = 1'b1;
            win_valid_d = (row_eff == 2'd2) && (col_eff >= CW'(2));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q       <= '0;
            row_q       <= '0;
            bptr_q      <= '0;
            left_q      <= '{default: '{default: '0}};
            in_q        <= '0;
            live_q      <= 1'b0;
            win_valid_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            bptr_q      <= bptr_d;
            left_q      <= left_d;
            in_q        <= in_d;
            live_q      <= live_d;
            win_valid_q <= win_valid_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            assign win[(3*gi + 0)*WIDTH +: WIDTH] = left_q[gi][0];
            assign win[(3*gi + 1)*WIDTH +: WIDTH] = left_q[gi][1];
            assign win[(3*gi + 2)*WIDTH +: WIDTH] = right[gi];
        end
    endgenerate

    assign win_valid = win_valid_q;

endmodule

// File: tb/tb_lbp_window.sv
// Bench for lbp_window. It runs two instances side by side on one stream:
// one with LINE_LEN=4 and one with LINE_LEN=3, both with WIDTH=8.
module tb_lbp_window;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce  = 1'b0;
    logic        sof = 1'b0;
    logic [7:0]  pin = '0;
    logic [71:0] win4, win3;
    logic        v4, v3;

    always #5 clk = ~clk;

    lbp_window #(.WIDTH(8), .LINE_LEN(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in        (pin),
`ifdef LBP_WINDOW_SOF_EN
        .sof       (sof),
`endif
        .win       (win4),
        .win_valid (v4)
    );

    lbp_window #(.WIDTH(8), .LINE_LEN(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in        (pin),
`ifdef LBP_WINDOW_SOF_EN
        .sof       (sof),
`endif
        .win       (win3),
        .win_valid (v3)
    );

    // Model: every pixel accepted since the last reset or start of frame.
    int          hist[$];
    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 0;
    logic        ev4 = 0, ev3 = 0;
    logic [71:0] ew4 = '0, ew3 = '0;

    // The window is in-image when the newest pixel sits at row >= 2 and
    // column >= 2 of a raster of width L.
    function automatic logic model_valid(int L);
        int k;
        k = hist.size() - 1;
        if (k < 0) return 1'b0;
        return (k / L >= 2) && (k % L >= 2);
    endfunction

    // Slot (i,j) is the pixel (2-i) rows and (2-j) columns back from the newest pixel.
    function automatic logic [71:0] model_win(int L);
        logic [71:0] w;
        int k, idx;
        w = '0;
        k = hist.size() - 1;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                idx = k - (2 - i) * L - (2 - j);
                w[(3*i + j)*8 +: 8] = 8'(hist[idx]);
            end
        return w;
    endfunction

    function automatic logic [71:0] pack9(input int a [9]);
        logic [71:0] w;
        for (int s = 0; s < 9; s++) w[s*8 +: 8] = 8'(a[s]);
        return w;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model. The outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("valid4", 72'(v4), 72'(ev4));
            if (ev4) check("win4", win4, ew4);
            check("valid3", 72'(v3), 72'(ev3));
            if (ev3) check("win3", win3, ew3);
        end
    end

    task automatic accept(input int p, input bit s);
        @(negedge clk);
        ce  = 1'b1;
        pin = 8'(p);
        sof = s;
        @(posedge clk);
        #1;
        ce  = 1'b0;
        sof = 1'b0;
        if (s) hist.delete();
        hist.push_back(p & 255);
        ev4 = model_valid(4);
        if (ev4) ew4 = model_win(4);
        ev3 = model_valid(3);
        if (ev3) ew3 = model_win(3);
        $display("pixel %0d: valid4=%0b win4=%h valid3=%0b win3=%h", p, v4, win4, v3, win3);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // The reset is asserted between clock edges, and its effect must be seen at once.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        hist.delete();
        ev4 = 1'b0;
        ev3 = 1'b0;
        #1;
        check("rst_win4", win4, '0);
        check("rst_valid4", 72'(v4), '0);
        check("rst_win3", win3, '0);
        check("rst_valid3", 72'(v3), '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int cnt4, cnt3;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("init_win4", win4, '0);
        check("init_valid4", 72'(v4), '0);
        check("init_win3", win3, '0);
        check("init_valid3", 72'(v3), '0);
        @(negedge clk);
        rst    = 1'b1;
        chk_en = 1;

        // Continuous stream 0..15, with hand-computed pins.
        cnt4 = 0;
        cnt3 = 0;
        for (int p = 0; p < 16; p++) begin
            accept(p, 1'b0);
            if (v4) cnt4++;
            if (v3) cnt3++;
            if (p == 8)  check("pin3_p8",  win3, pack9('{0, 1, 2, 3, 4, 5, 6, 7, 8}));
            if (p == 10) check("pin4_p10", win4, pack9('{0, 1, 2, 4, 5, 6, 8, 9, 10}));
            if (p == 11) check("pin4_p11", win4, pack9('{1, 2, 3, 5, 6, 7, 9, 10, 11}));
            if (p == 12 || p == 13) check("pin4_gap", 72'(v4), '0);
            if (p == 14) check("pin4_p14", win4, pack9('{4, 5, 6, 8, 9, 10, 12, 13, 14}));
            if (p == 15) check("pin4_p15", win4, pack9('{5, 6, 7, 9, 10, 11, 13, 14, 15}));
        end
        check("count4", 72'(cnt4), 72'(4));
        check("count3", 72'(cnt3), 72'(3));

        // Restart, stop partway through row 2, and reset asynchronously there.
        async_reset();
        for (int p = 0; p < 10; p++) accept(p, 1'b0);
        async_reset();

        // Restart with random idle gaps of 1 to 5 cycles.
        cnt4 = 0;
        for (int p = 0; p < 16; p++) begin
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 5));
            accept(p, 1'b0);
            if (v4) cnt4++;
            if (p == 10) check("gap_pin4_p10", win4, pack9('{0, 1, 2, 4, 5, 6, 8, 9, 10}));
        end
        idle(3);
        check("gap_count4", 72'(cnt4), 72'(4));

        // A longer run with arbitrary values, to exercise row saturation.
        for (int p = 16; p < 44; p++) accept((p * 37 + 5) & 255, 1'b0);

`ifdef LBP_WINDOW_SOF_EN
        // Start a new frame after 11 pixels of the current one.
        async_reset();
        for (int p = 0; p < 11; p++) accept(p, 1'b0);
        cnt4 = 0;
        accept(100, 1'b1);
        if (v4) cnt4++;
        for (int p = 1; p < 10; p++) begin
            accept(100 + p, 1'b0);
            if (v4) cnt4++;
        end
        check("sof_quiet4", 72'(cnt4), '0);
        accept(110, 1'b0);
        check("sof_pin4", win4, pack9('{100, 101, 102, 104, 105, 106, 108, 109, 110}));
`endif

        idle(2);
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
